// File: rtl/iot_riscv_pkg.sv
// Shared types and constants for the iot_riscv machine-mode trap controller.
// Holds the trap FSM encoding, the CSR addresses it decodes and the cause codes it reports.
package iot_riscv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_ENTER  = 2'd2,
        ST_RETURN = 2'd3
    } trap_state_e;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
    localparam logic [31:0] CAUSE_EBREAK  = 32'd3;
    localparam logic [31:0] CAUSE_ECALL   = 32'd11;
    localparam logic [31:0] CAUSE_MEI     = 32'h8000_000B;

    // Vectored mode lands the external interrupt at base + 4*11.
    localparam logic [31:0] VEC_MEI_OFFSET = 32'h0000_002C;

    function automatic logic [31:0] mstatus_view(input logic mie, input logic mpie);
        return {19'd0, 2'b11, 3'd0, mpie, 3'd0, mie, 3'd0};
    endfunction

endpackage

// File: rtl/iot_riscv_trap_ctrl_if.sv
// Signal bundle between the trap controller and its core/CSR-file neighbours.
// The master modport is the trap controller's view; slave is the surrounding core.
interface iot_riscv_trap_ctrl_if #(
    parameter int unsigned pc_size_p = 32
);
    logic                 id_valid_i;
    logic [pc_size_p-1:0] id_pc_i;
    logic                 id_illegal_i;
    logic                 id_ebreak_i;
    logic                 id_ecall_i;
    logic                 id_mret_i;
    logic                 irq_i;
    logic                 ex_busy_i;
    logic [31:0]          mtvec_i;
    logic [31:0]          mepc_i;
    logic                 csr_we_i;
    logic [11:0]          csr_addr_i;
    logic [31:0]          csr_wdata_i;
    logic                 stall_o;
    logic                 flush_o;
    logic                 redirect_o;
    logic [pc_size_p-1:0] redirect_pc_o;
    logic                 mepc_wr_o;
    logic [31:0]          mepc_wdata_o;
    logic [31:0]          mcause_o;
    logic [31:0]          mstatus_o;

    modport master (
        input  id_valid_i, id_pc_i, id_illegal_i, id_ebreak_i, id_ecall_i, id_mret_i,
        input  irq_i, ex_busy_i, mtvec_i, mepc_i, csr_we_i, csr_addr_i, csr_wdata_i,
        output stall_o, flush_o, redirect_o, redirect_pc_o, mepc_wr_o, mepc_wdata_o,
        output mcause_o, mstatus_o
    );

    modport slave (
        output id_valid_i, id_pc_i, id_illegal_i, id_ebreak_i, id_ecall_i, id_mret_i,
        output irq_i, ex_busy_i, mtvec_i, mepc_i, csr_we_i, csr_addr_i, csr_wdata_i,
        input  stall_o, flush_o, redirect_o, redirect_pc_o, mepc_wr_o, mepc_wdata_o,
        input  mcause_o, mstatus_o
    );

endinterface

// File: rtl/iot_riscv_trap_prio.sv
// Combinational trap priority encoder: an enabled interrupt beats illegal > ebreak > ecall,
// and mret is only honoured when nothing traps.
module iot_riscv_trap_prio
    import iot_riscv_pkg::*;
(
    input  logic        valid,
    input  logic        illegal,
    input  logic        ebreak,
    input  logic        ecall,
    input  logic        mret,
    input  logic        irq,
    input  logic        mie,
    output logic        take,
    output logic        is_irq,
    output logic        is_ret,
    output logic [31:0] cause
);

    // Pick the single highest-priority event for the decode-stage instruction.
    always_comb begin
        take   = 1'b0;
        is_irq = 1'b0;
        is_ret = 1'b0;
        cause  = 32'd0;
        if (valid && irq && mie) begin
            take   = 1'b1;
            is_irq = 1'b1;
            cause  = CAUSE_MEI;
        end else if (valid && illegal) begin
            take  = 1'b1;
            cause = CAUSE_ILLEGAL;
        end else if (valid && ebreak) begin
            take  = 1'b1;
            cause = CAUSE_EBREAK;
        end else if (valid && ecall) begin
            take  = 1'b1;
            cause = CAUSE_ECALL;
        end else if (valid && mret) begin
            is_ret = 1'b1;
        end else begin
            is_ret = 1'b0;
        end
    end

endmodule

// File: rtl/iot_riscv_trap_ctrl.sv
// Machine-mode trap controller: detects traps/mret in decode, drains execute, then redirects
// fetch while owning mstatus.MIE/MPIE and mcause.
module iot_riscv_trap_ctrl
    import iot_riscv_pkg::*;
#(
    parameter int unsigned pc_size_p = 32
) (
    input  logic                 main_clk_i,
    input  logic                 main_rst_an_i,
    iot_riscv_trap_ctrl_if.master bus
);

    trap_state_e          state_r;
    trap_state_e          state_nxt_s;

    logic                 prio_take_s;
    logic                 prio_is_irq_s;
    logic                 prio_is_ret_s;
    logic [31:0]          prio_cause_s;

    logic                 latch_s;
    logic [31:0]          cause_r;
    logic [pc_size_p-1:0] pc_r;
    logic                 irq_r;
    logic                 ret_r;

    logic                 mie_r;
    logic                 mpie_r;
    logic [31:0]          mcause_r;
    logic                 mie_nxt_s;
    logic                 mpie_nxt_s;
    logic [31:0]          mcause_nxt_s;

    logic                 stall_s;
    logic                 flush_s;
    logic                 redirect_s;
    logic                 mepc_wr_s;
    logic [pc_size_p-1:0] redirect_pc_s;
    logic [31:0]          mepc_wdata_s;

    logic [31:0]          base_s;
    logic [31:0]          trap_target_s;
    logic [31:0]          ret_target_s;
    logic                 csr_mstatus_we_s;
    logic                 csr_mcause_we_s;

    iot_riscv_trap_prio u_prio (
        .valid   (bus.id_valid_i),
        .illegal (bus.id_illegal_i),
        .ebreak  (bus.id_ebreak_i),
        .ecall   (bus.id_ecall_i),
        .mret    (bus.id_mret_i),
        .irq     (bus.irq_i),
        .mie     (mie_r),
        .take    (prio_take_s),
        .is_irq  (prio_is_irq_s),
        .is_ret  (prio_is_ret_s),
        .cause   (prio_cause_s)
    );

    assign base_s           = {bus.mtvec_i[31:2], 2'b00};
    assign trap_target_s    = (irq_r && (bus.mtvec_i[1:0] == 2'b01)) ? (base_s + VEC_MEI_OFFSET) : base_s;
    assign ret_target_s     = bus.mepc_i & 32'hFFFF_FFFC;
    assign csr_mstatus_we_s = bus.csr_we_i && (bus.csr_addr_i == CSR_MSTATUS);
    assign csr_mcause_we_s  = bus.csr_we_i && (bus.csr_addr_i == CSR_MCAUSE);

    // Trap FSM state register.
    always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
        if (!main_rst_an_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and pipeline-control decode; redirect data is zero unless its strobe is high.
    always_comb begin
        state_nxt_s   = state_r;
        latch_s       = 1'b0;
        stall_s       = 1'b0;
        flush_s       = 1'b0;
        redirect_s    = 1'b0;
        mepc_wr_s     = 1'b0;
        redirect_pc_s = '0;
        mepc_wdata_s  = 32'd0;
        case (state_r)
            ST_IDLE: begin
                if (prio_take_s || prio_is_ret_s) begin
                    stall_s     = 1'b1;
                    latch_s     = 1'b1;
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                stall_s = 1'b1;
                if (bus.ex_busy_i) begin
                    state_nxt_s = ST_DRAIN;
                end else if (ret_r) begin
                    state_nxt_s = ST_RETURN;
                end else begin
                    state_nxt_s = ST_ENTER;
                end
            end
            ST_ENTER: begin
                stall_s       = 1'b1;
                flush_s       = 1'b1;
                redirect_s    = 1'b1;
                mepc_wr_s     = 1'b1;
                redirect_pc_s = trap_target_s[pc_size_p-1:0];
                mepc_wdata_s  = 32'(pc_r);
                state_nxt_s   = ST_IDLE;
            end
            ST_RETURN: begin
                stall_s       = 1'b1;
                flush_s       = 1'b1;
                redirect_s    = 1'b1;
                redirect_pc_s = ret_target_s[pc_size_p-1:0];
                state_nxt_s   = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Capture the detected event so DRAIN can ignore the decode inputs.
    always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
        if (!main_rst_an_i) begin
            cause_r <= 32'd0;
            pc_r    <= '0;
            irq_r   <= 1'b0;
            ret_r   <= 1'b0;
        end else if (latch_s) begin
            cause_r <= prio_cause_s;
            pc_r    <= bus.id_pc_i;
            irq_r   <= prio_is_irq_s;
            ret_r   <= prio_is_ret_s;
        end
    end

    // CSR field updates: trap entry/return take precedence over a same-cycle CSR write.
    always_comb begin
        mie_nxt_s    = mie_r;
        mpie_nxt_s   = mpie_r;
        mcause_nxt_s = mcause_r;
        if (state_r == ST_ENTER) begin
            mie_nxt_s    = 1'b0;
            mpie_nxt_s   = mie_r;
            mcause_nxt_s = cause_r;
        end else if (state_r == ST_RETURN) begin
            mie_nxt_s  = mpie_r;
            mpie_nxt_s = 1'b1;
            if (csr_mcause_we_s) begin
                mcause_nxt_s = bus.csr_wdata_i;
            end else begin
                mcause_nxt_s = mcause_r;
            end
        end else begin
            if (csr_mstatus_we_s) begin
                mie_nxt_s  = bus.csr_wdata_i[3];
                mpie_nxt_s = bus.csr_wdata_i[7];
            end else begin
                mie_nxt_s  = mie_r;
                mpie_nxt_s = mpie_r;
            end
            if (csr_mcause_we_s) begin
                mcause_nxt_s = bus.csr_wdata_i;
            end else begin
                mcause_nxt_s = mcause_r;
            end
        end
    end

    // Architectural mstatus/mcause state.
    always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
        if (!main_rst_an_i) begin
            mie_r    <= 1'b0;
            mpie_r   <= 1'b0;
            mcause_r <= 32'd0;
        end else begin
            mie_r    <= mie_nxt_s;
            mpie_r   <= mpie_nxt_s;
            mcause_r <= mcause_nxt_s;
        end
    end

    assign bus.stall_o       = stall_s;
    assign bus.flush_o       = flush_s;
    assign bus.redirect_o    = redirect_s;
    assign bus.redirect_pc_o = redirect_pc_s;
    assign bus.mepc_wr_o     = mepc_wr_s;
    assign bus.mepc_wdata_o  = mepc_wdata_s;
    assign bus.mcause_o      = mcause_r;
    assign bus.mstatus_o     = mstatus_view(mie_r, mpie_r);

endmodule

// File: doc/iot_riscv_trap_ctrl.md
# iot_riscv_trap_ctrl

Machine-mode trap controller for the iot_riscv core. Sits between the decode stage and the CSR file: detects synchronous exceptions (illegal, ebreak, ecall), machine external interrupts and mret, drains the execute stage, then redirects fetch. It owns mstatus.MIE/MPIE and mcause, writes mepc into the CSR file, and consumes mtvec/mepc from it.

## Interface
Parameters:
- pc_size_p, 32, program-counter width (1..32)

Ports (one clock; reset is asynchronous and active-low):
- main_clk_i  in  1  core clock
- main_rst_an_i  in  1  async reset, low-active
- id_valid_i  in  1  decode stage holds a valid instruction
- id_pc_i  in  pc_size_p  PC of the decode-stage instruction
- id_illegal_i / id_ebreak_i / id_ecall_i / id_mret_i  in  1 each  decoded instruction class
- irq_i  in  1  machine external interrupt, level
- ex_busy_i  in  1  execute stage still holds an uncommitted instruction
- mtvec_i  in  32  mtvec from CSR file
- mepc_i  in  32  mepc from CSR file
- csr_we_i  in  1  CSR write strobe from execute
- csr_addr_i  in  12  CSR write address
- csr_wdata_i  in  32  CSR write data
- stall_o  out  1  hold fetch/decode
- flush_o  out  1  kill fetch/decode contents
- redirect_o  out  1  load new PC
- redirect_pc_o  out  pc_size_p  new PC
- mepc_wr_o  out  1  mepc write strobe to CSR file
- mepc_wdata_o  out  32  mepc write value
- mcause_o  out  32  mcause register
- mstatus_o  out  32  mstatus view: bit 3 MIE, bit 7 MPIE, bits 12:11 = 2'b11, rest 0

## Operation
- States: IDLE, DRAIN, ENTER, RETURN.
- IDLE, id_valid_i=1, priority: irq_i & MIE → interrupt; else id_illegal_i (cause 2) > id_ebreak_i (3) > id_ecall_i (11) → exception; else id_mret_i → return. Interrupt cause 32'h8000_000B.
- On trap event: latch cause, latch pc = id_pc_i, go DRAIN. On mret: go DRAIN with return flag.
- DRAIN: stall_o=1; stay while ex_busy_i=1; when 0 → ENTER (trap) or RETURN (mret). Inputs other than ex_busy_i ignored; irq deassertion does not cancel.
- ENTER (1 cycle): redirect_o=flush_o=mepc_wr_o=1; mepc_wdata_o = latched pc zero-extended; mcause ← latched cause; MPIE ← MIE; MIE ← 0; → IDLE.
- Target: base = {mtvec_i[31:2],2'b00}; mtvec_i[1:0]=01 and interrupt → base + 4*11 (= base+0x2C); otherwise base. Truncated to pc_size_p bits, +0x2C wraps modulo 2^32.
- RETURN (1 cycle): redirect_o=flush_o=1; redirect_pc_o = mepc_i[pc_size_p-1:0] with bits 1:0 forced 0; MIE ← MPIE; MPIE ← 1; → IDLE.
- CSR writes (any state): 12'h300 updates MIE=wdata[3], MPIE=wdata[7]; 12'h342 updates mcause. Same-cycle ENTER/RETURN updates override the CSR write for the affected fields.
- Reset (any state): state IDLE, mcause 0, MIE 0, MPIE 0; all strobes 0; no pending redirect survives.

## Timing
- Reset values: stall_o, flush_o, redirect_o, mepc_wr_o 0; redirect_pc_o 0; mepc_wdata_o 0; mcause_o 0; mstatus_o 32'h0000_1800.
- stall_o is combinational: 1 in the IDLE detection cycle, all of DRAIN, and ENTER/RETURN.
- Latency with ex_busy_i=0: detect cycle N, DRAIN N+1, ENTER/RETURN N+2 redirect; new PC fetched N+3.
- redirect_pc_o and mepc_wdata_o valid only while their strobe is 1; 0 otherwise.
- mcause/mstatus visible on outputs the cycle after ENTER/RETURN.

## Structure
- iot_riscv_pkg: state enum trap_state_e, CSR address constants (mstatus 12'h300, mcause 12'h342), cause constants (illegal 2, ebreak 3, ecall 11, mei 32'h8000_000B).
- One sub-module: iot_riscv_trap_prio, combinational priority encoder (event inputs, MIE → take, is_irq, cause).

## Test plan
- Reset then idle: all outputs at reset values, mstatus_o=32'h1800.
- ecall at id_pc_i=0x100, mtvec_i=0x0000_0200, ex_busy_i=0 → ENTER 2 cycles later, redirect_pc_o=0x200, mepc_wdata_o=0x100, mcause_o=11, MIE 0.
- csr write mstatus=0x8, irq_i=1, mtvec_i=0x0000_0401, ex_busy_i=1 for 3 cycles → DRAIN 3 cycles, redirect_pc_o=0x42C, mcause_o=0x8000_000B, MPIE=1, MIE=0.
- illegal+ecall same cycle → mcause_o=2; irq with MIE=0 → no trap.
- mret with mepc_i=0x103, MPIE=1 → redirect_pc_o=0x100, MIE=1, MPIE=1.
- Reset asserted during DRAIN → no redirect, state IDLE; csr write to mcause in ENTER cycle → trap cause wins.
